// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter sharing one FIFO between NREQ valid/ready producers.
// Latency: 1-cycle bubble from IDLE to the first write; accepted beats reach the FIFO on the same edge.
// Backpressure: i_wr_full holds grant, beat count and pointer; no beat is accepted while full.
module fifo_wr_arbiter #(
  parameter int DATAW    = 8,
  parameter int NREQ     = 4,
  parameter int MAXBURST = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         i_req_valid,
  input  logic [NREQ*DATAW-1:0]   i_req_data,
  output logic [NREQ-1:0]         o_req_ready,
  output logic [NREQ-1:0]         o_grant,
  output logic                    o_busy,
  output logic                    o_wr_en,
  output logic [DATAW-1:0]        o_wr_data,
  input  logic                    i_wr_full
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(MAXBURST + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAXBURST - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NREQ - 1);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   gnt_idx_q, gnt_idx_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;

  logic            cur_vld;
  logic            xfer;
  logic            release_now;
  logic [IW-1:0]   rel_ptr;
  logic [IW:0]     idle_sel;
  logic [IW:0]     rel_sel;

  // Modulo-NREQ increment that also works for non-power-of-two NREQ.
  function automatic logic [IW-1:0] inc_idx(input logic [IW-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  // First valid requester scanning from ptr upward with wrap; MSB of result flags a hit.
  function automatic logic [IW:0] select_req(input logic [IW-1:0] ptr,
                                             input logic [NREQ-1:0] vld);
    logic [IW-1:0] cand;
    logic [IW-1:0] pick;
    logic          found;
    cand  = ptr;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && vld[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
      cand = inc_idx(cand);
    end
    return {found, pick};
  endfunction

  assign cur_vld     = (state_q == S_GRANT) && i_req_valid[gnt_idx_q];
  assign xfer        = cur_vld && !i_wr_full;
  // A full FIFO blocks only the burst-length release; a dropped valid releases regardless.
  assign release_now = (xfer && (beat_cnt_q == LAST_BEAT)) || !cur_vld;
  assign rel_ptr     = inc_idx(gnt_idx_q);
  assign idle_sel    = select_req(rr_ptr_q, i_req_valid);
  assign rel_sel     = select_req(rel_ptr, i_req_valid);

  // Grant-side outputs are a pure function of the registered grant, so reset clears them at once.
  always_comb begin
    o_req_ready = '0;
    o_grant     = '0;
    o_busy      = 1'b0;
    o_wr_en     = 1'b0;
    o_wr_data   = '0;
    if (state_q == S_GRANT) begin
      o_busy               = 1'b1;
      o_grant[gnt_idx_q]   = 1'b1;
      o_req_ready[gnt_idx_q] = !i_wr_full;
      o_wr_en              = xfer;
      for (int r = 0; r < NREQ; r++) begin
        if (gnt_idx_q == IW'(r)) begin
          o_wr_data = i_req_data[r*DATAW +: DATAW];
        end
      end
    end
  end

  // Next-state: pick in IDLE with a bubble, re-pick on release without one.
  always_comb begin
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (|i_req_valid) begin
          gnt_idx_d  = idle_sel[IW-1:0];
          beat_cnt_d = '0;
          state_d    = S_GRANT;
        end
      end
      S_GRANT: begin
        if (release_now) begin
          rr_ptr_d   = rel_ptr;
          beat_cnt_d = '0;
          if (rel_sel[IW]) begin
            gnt_idx_d = rel_sel[IW-1:0];
          end else begin
            state_d = S_IDLE;
          end
        end else if (xfer) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset abandons any burst and restores requester 0 as top priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      gnt_idx_q  <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares one `fifo` instance (DATAW-wide, single clock) between NREQ producers. Each producer uses a valid/ready handshake. The arbiter drives the FIFO's `i_wr_en`/`i_wr_data` and observes `o_wr_full`. A granted producer holds the port for a burst of up to MAXBURST beats, so short packets from one source stay contiguous in the FIFO.

## Interface
- DATAW, 8: data width; must match the attached fifo.
- NREQ, 4: number of requesters, ≥ 2.
- MAXBURST, 4: maximum beats per grant, ≥ 1.

- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_req_valid  in  NREQ  requester r has a beat on bit r.
- i_req_data  in  NREQ*DATAW  requester r data at [r*DATAW +: DATAW].
- o_req_ready  out  NREQ  beat of requester r accepted this cycle when valid and ready are both high.
- o_grant  out  NREQ  one-hot current grant; all zeros when idle.
- o_busy  out  1  FSM is in GRANT.
- o_wr_en  out  1  to fifo i_wr_en.
- o_wr_data  out  DATAW  to fifo i_wr_data.
- i_wr_full  in  1  from fifo o_wr_full.

## Operation
- Registered state:
  - FSM {IDLE, GRANT}.
  - gnt_idx: $clog2(NREQ) bits.
  - rr_ptr: $clog2(NREQ) bits; highest-priority index.
  - beat_cnt: $clog2(MAXBURST+1) bits.
- Selection function: the first r with i_req_valid[r] set, scanning rr_ptr, rr_ptr+1, … modulo NREQ.
- IDLE:
  - Nothing is granted; o_req_ready = 0.
  - If any valid is set: at the next edge, gnt_idx ← selection, beat_cnt ← 0, FSM → GRANT.
  - This costs one bubble cycle.
- GRANT, combinational outputs:
  - o_grant = onehot(gnt_idx).
  - o_req_ready[gnt_idx] = !i_wr_full; all other ready bits are 0.
  - o_wr_en = i_req_valid[gnt_idx] & !i_wr_full.
  - o_wr_data = slice gnt_idx of i_req_data.
- Transfer: o_wr_en high at an edge. beat_cnt increments.
- Release: at an edge where either of these holds:
  - (a) a transfer occurs and beat_cnt+1 == MAXBURST, or
  - (b) i_req_valid[gnt_idx] = 0.
- On release:
  - rr_ptr ← gnt_idx+1 mod NREQ.
  - Rerun selection from the new pointer over the current i_req_valid.
  - If a requester is found: gnt_idx ← it, beat_cnt ← 0, stay in GRANT. There is no bubble between back-to-back grants.
  - Otherwise go to IDLE.
- A requester that is the only one valid regains the grant immediately after its burst.
- Full: while i_wr_full = 1, no transfer occurs. Grant, beat_cnt and rr_ptr are held. A valid granted requester is not released.
- When not in GRANT, o_wr_data = 0.
- Requesters must hold data stable while valid and not ready. The arbiter does not buffer data.

## Timing
- Reset (asynchronous, immediate):
  - FSM = IDLE, rr_ptr = 0, gnt_idx = 0, beat_cnt = 0.
  - Outputs o_req_ready = 0, o_grant = 0, o_busy = 0, o_wr_en = 0, o_wr_data = 0.
- Reset mid-burst: the burst is abandoned and no further beat is written. After reset release, requester 0 has top priority.
- Latency:
  - From the first valid in IDLE to the first write: 1 cycle.
  - From accepted beat to FIFO write: 0 cycles (same edge).
- Throughput: one beat per cycle while the grant is held and the FIFO is not full.
- Full dependency: i_wr_full from the fifo updates the cycle after the filling write. o_wr_en is therefore never high while i_wr_full = 1.
- Wrap-around: gnt_idx = NREQ-1 releases with rr_ptr → 0.
- Simultaneous release and the same requester re-asserting: valid is sampled at the release edge, per the release rule.

## Test plan
- Single source, MAXBURST = 4: requester 0 presents 1, 2, 3, 4 from cycle 0.
  - o_grant = 0001 from cycle 1.
  - o_wr_en high on cycles 1–4 with data 1, 2, 3, 4.
  - Grant re-issued to requester 0 at cycle 5 with no bubble.
- Fairness, NREQ = 4, MAXBURST = 2: all sources continuously valid, each sending its index+0x10.
  - FIFO write order is 10, 10, 11, 11, 12, 12, 13, 13, 10, …
  - No idle cycle between bursts.
- Backpressure: fifo DEPTH = 4, one requester streams, nothing is read.
  - After 4 writes, i_wr_full = 1.
  - o_wr_en = 0 and o_req_ready = 0, with o_grant held.
  - Reading one entry gives exactly one further write.
- Early release: requester 1 is granted and drops valid after 1 beat while requesters 2 and 3 are valid.
  - Requester 2 is granted on the next cycle.
  - rr_ptr = 2, then 3 after requester 2's burst.
- Wrap: requester 3 finishes its burst while requesters 0 and 3 are valid.
  - Requester 0 is granted next, then requester 3.
- Reset mid-burst: assert rst_n = 0 mid-cycle during the beat-2 transfer.
  - All outputs go to 0 without waiting for a clock edge.
  - After release, with requesters 0 and 2 valid, requester 0 is granted first.
